// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types and the channel-select width helper for the PWM bank
package pwm_pkg;
  typedef enum logic {PWM_EDGE = 1'b0, PWM_CENTER = 1'b1} pwm_mode_t;
  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: one PWM channel with shadowed period/compare/mode; ports: clk, rst, en, wr + wr_* write data, pend/wrap/pwm outputs
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_period,
  input  logic [WIDTH-1:0] wr_compare,
  input  pwm_mode_t        wr_mode,
  output logic             pend,
  output logic             wrap,
  output logic             pwm
);
  logic [WIDTH-1:0] ctr_q, ctr_d, per_a_q, per_a_d, cmp_a_q, cmp_a_d;
  logic [WIDTH-1:0] per_s_q, per_s_d, cmp_s_q, cmp_s_d, dec;
  pwm_mode_t        mode_a_q, mode_a_d, mode_s_q, mode_s_d;
  dir_t             dir_q, dir_d;
  logic             pend_q, pend_d, wrap_q, wrap_d, pwm_q, pwm_d, load, down;
  always_comb begin
    dec    = ctr_q - WIDTH'(1);
    ctr_d  = ctr_q + WIDTH'(1);
    dir_d  = DIR_UP;
    wrap_d = 1'b0;
    // centre mode counts down once it has peaked; a step down to 0 is the wrap
    down   = mode_a_q == PWM_CENTER &&
             (dir_q == DIR_DOWN || (per_a_q != '0 && ctr_q >= per_a_q));
    if (!en) begin
      ctr_d = '0;
    end else if (down) begin
      ctr_d  = dec;
      wrap_d = dec == '0;
      dir_d  = (dec == '0) ? DIR_UP : DIR_DOWN;
    end else if (ctr_q >= per_a_q) begin
      ctr_d  = '0;
      wrap_d = 1'b1;
    end
    load     = !en || wrap_d;
    per_a_d  = load ? per_s_q : per_a_q;
    cmp_a_d  = load ? cmp_s_q : cmp_a_q;
    mode_a_d = load ? mode_s_q : mode_a_q;
    // a write landing on a load cycle stays pending; the load takes the old shadow
    per_s_d  = wr ? wr_period : per_s_q;
    cmp_s_d  = wr ? wr_compare : cmp_s_q;
    mode_s_d = wr ? wr_mode : mode_s_q;
    pend_d   = wr || (pend_q && !load);
    pwm_d    = en && (ctr_d < cmp_a_d);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ctr_q    <= '0;
      dir_q    <= DIR_UP;
      per_a_q  <= '0;
      cmp_a_q  <= '0;
      mode_a_q <= PWM_EDGE;
      per_s_q  <= '0;
      cmp_s_q  <= '0;
      mode_s_q <= PWM_EDGE;
      pend_q   <= 1'b0;
      wrap_q   <= 1'b0;
      pwm_q    <= 1'b0;
    end else begin
      ctr_q    <= ctr_d;
      dir_q    <= dir_d;
      per_a_q  <= per_a_d;
      cmp_a_q  <= cmp_a_d;
      mode_a_q <= mode_a_d;
      per_s_q  <= per_s_d;
      cmp_s_q  <= cmp_s_d;
      mode_s_q <= mode_s_d;
      pend_q   <= pend_d;
      wrap_q   <= wrap_d;
      pwm_q    <= pwm_d;
    end
  end
  assign pend = pend_q;
  assign wrap = wrap_q;
  assign pwm  = pwm_q;
endmodule

// File: rtl/pwm_bank.sv
// pwm_bank: CHANNELS independent shadowed PWM channels; ports: clk, rst, en, cfg_* write port, cfg_err, pend/wrap/pwm per channel
module pwm_bank
  import pwm_pkg::*;
#(
  parameter int  CHANNELS = 4,
  parameter int  WIDTH    = 24,
  localparam int CH_W     = ch_w(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] en,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [WIDTH-1:0]    cfg_period,
  input  logic [WIDTH-1:0]    cfg_compare,
  input  logic                cfg_mode,
  output logic                cfg_err,
  output logic [CHANNELS-1:0] pend,
  output logic [CHANNELS-1:0] wrap,
  output logic [CHANNELS-1:0] pwm
);
  localparam logic [CH_W:0] NCH = (CH_W + 1)'(CHANNELS);
  logic ready_q, ready_d, err_q, err_d, acc;
  always_comb begin
    acc     = cfg_valid && ready_q;
    ready_d = 1'b1;
    err_d   = acc && ({1'b0, cfg_ch} >= NCH);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end
  assign cfg_ready = ready_q;
  assign cfg_err   = err_q;
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pwm_channel #(.WIDTH(WIDTH)) u_ch (
      .clk       (clk),
      .rst       (rst),
      .en        (en[i]),
      .wr        (acc && cfg_ch == CH_W'(i)),
      .wr_period (cfg_period),
      .wr_compare(cfg_compare),
      .wr_mode   (pwm_mode_t'(cfg_mode)),
      .pend      (pend[i]),
      .wrap      (wrap[i]),
      .pwm       (pwm[i])
    );
  end
endmodule

// File: tb/tb_pwm_bank.sv
// tb_pwm_bank: scoreboard bench for pwm_bank with directed, hand-computed waveforms
module tb_pwm_bank;
  localparam int N = 3;
  localparam int W = 8;
  logic clk = 1'b0, rst = 1'b1, cfg_valid = 1'b0, cfg_mode = 1'b0;
  logic [N-1:0] en = '0;
  logic [1:0] cfg_ch = '0;
  logic [W-1:0] cfg_period = '0, cfg_compare = '0;
  logic cfg_ready, cfg_err;
  logic [N-1:0] pend, wrap, pwm;
  int cyc = 0, checks = 0, errors = 0;
  logic done = 1'b0, reported = 1'b0;
  typedef struct {int cyc; int sig; int ch; logic v; string tag;} exp_t;
  exp_t q[$];

  pwm_bank #(.CHANNELS(N), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_period(cfg_period), .cfg_compare(cfg_compare),
    .cfg_mode(cfg_mode), .cfg_err(cfg_err), .pend(pend), .wrap(wrap), .pwm(pwm)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic obs(input int sig, input int ch);
    return sig == 0 ? pwm[ch] : sig == 1 ? wrap[ch] : sig == 2 ? pend[ch] : sig == 3 ? cfg_err : cfg_ready;
  endfunction

  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc == cyc) begin
        checks++;
        if (obs(q[i].sig, q[i].ch) !== q[i].v) begin
          errors++;
          $display("FAIL %s cyc=%0d ch=%0d got=%b exp=%b", q[i].tag, cyc, q[i].ch, obs(q[i].sig, q[i].ch), q[i].v);
        end
        q.delete(i);
      end
    end
    if (done && !reported) begin
      reported = 1'b1;
      checks++;
      if (q.size() != 0) begin
        errors++;
        $display("FAIL unconsumed_expectations got=%0d exp=0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  task automatic chk(input int sig, input int ch, input logic v, input int dly, input string tag);
    exp_t e;
    e.cyc = cyc + dly;
    e.sig = sig;
    e.ch  = ch;
    e.v   = v;
    e.tag = tag;
    q.push_back(e);
  endtask

  task automatic chk_str(input int sig, input int ch, input string s, input string tag);
    for (int i = 0; i < s.len(); i++) chk(sig, ch, s[i] == "1", i + 1, tag);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = '0;
    cfg_valid = 1'b0;
    chk(4, 0, 1'b0, 1, "ready_in_rst");
    chk(3, 0, 1'b0, 2, "err_rst");
    for (int c = 0; c < N; c++) begin
      chk(0, c, 1'b0, 2, "pwm_rst");
      chk(1, c, 1'b0, 2, "wrap_rst");
      chk(2, c, 1'b0, 2, "pend_rst");
    end
    tick(2);
    rst = 1'b0;
    chk(4, 0, 1'b1, 1, "ready_after_rst");
    tick();
  endtask

  task automatic cfg(input int ch, input int p, input int c, input logic m);
    cfg_valid = 1'b1;
    cfg_ch = 2'(ch);
    cfg_period = W'(p);
    cfg_compare = W'(c);
    cfg_mode = m;
    chk(3, 0, ch >= N, 1, "cfg_err");
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic setup(input int ch, input int p, input int c, input logic m);
    chk(2, ch, 1'b1, 1, "pend_set");
    chk(2, ch, 1'b0, 2, "pend_load_disabled");
    cfg(ch, p, c, m);
    tick();
  endtask

  initial begin
    // edge mode P=4 C=2
    do_reset();
    setup(0, 4, 2, 1'b0);
    en = 3'b001;
    chk_str(0, 0, "1000110001", "edge_pwm");
    chk_str(1, 0, "0000100001", "edge_wrap");
    chk_str(0, 1, "0000000000", "idle_ch1_pwm");
    tick(10);
    // compare boundaries
    do_reset();
    setup(0, 4, 0, 1'b0);
    setup(1, 4, 6, 1'b0);
    setup(2, 0, 1, 1'b0);
    en = 3'b111;
    chk_str(0, 0, "00000000", "c0_pwm");
    chk_str(0, 1, "11111111", "c_gt_p_pwm");
    chk_str(0, 2, "11111111", "p0_pwm");
    chk_str(1, 2, "11111111", "p0_wrap");
    tick(8);
    // centre mode P=3 C=2
    do_reset();
    setup(0, 3, 2, 1'b1);
    en = 3'b001;
    chk_str(0, 0, "100011100011", "center_pwm");
    chk_str(1, 0, "000001000001", "center_wrap");
    tick(12);
    // shadow update with a double write on channel 1
    do_reset();
    setup(0, 4, 2, 1'b0);
    setup(1, 4, 2, 1'b0);
    en = 3'b011;
    chk_str(0, 0, "100011000110001", "shadow_ch0_pwm");
    chk_str(0, 1, "100011111000001", "shadow_ch1_pwm");
    chk_str(1, 1, "000010000000001", "shadow_ch1_wrap");
    chk_str(2, 1, "001100000000000", "shadow_ch1_pend");
    tick(2);
    cfg(1, 7, 3, 1'b0);
    cfg(1, 9, 5, 1'b0);
    tick(11);
    // write on the wrap cycle is deferred one period
    do_reset();
    setup(0, 4, 2, 1'b0);
    en = 3'b001;
    chk_str(0, 0, "10001100011111000001", "same_cyc_pwm");
    chk_str(1, 0, "00001000010000000001", "same_cyc_wrap");
    chk_str(2, 0, "0000111110", "same_cyc_pend");
    tick(4);
    cfg(0, 9, 5, 1'b0);
    tick(15);
    // disable mid-period loads the pending write
    do_reset();
    setup(0, 4, 2, 1'b0);
    en = 3'b001;
    chk_str(0, 0, "10001111000001", "dis_pwm");
    chk_str(1, 0, "00000000000001", "dis_wrap");
    chk_str(2, 0, "00100000000000", "dis_pend");
    tick(2);
    cfg(0, 9, 5, 1'b0);
    en = 3'b000;
    tick();
    en = 3'b001;
    tick(10);
    // reset mid-period overrides a concurrent write
    do_reset();
    setup(0, 4, 2, 1'b0);
    en = 3'b001;
    chk(0, 0, 1'b1, 1, "pre_rst_pwm");
    chk(0, 0, 1'b0, 2, "mid_rst_pwm");
    chk(1, 0, 1'b0, 2, "mid_rst_wrap");
    chk(2, 1, 1'b0, 2, "mid_rst_pend");
    chk(4, 0, 1'b0, 2, "mid_rst_ready");
    chk(4, 0, 1'b1, 3, "post_rst_ready");
    chk(0, 0, 1'b0, 3, "post_rst_pwm");
    chk(1, 0, 1'b1, 3, "post_rst_wrap");
    chk(2, 1, 1'b0, 3, "post_rst_pend");
    tick();
    rst = 1'b1;
    cfg_valid = 1'b1;
    cfg_ch = 2'd1;
    tick();
    rst = 1'b0;
    cfg_valid = 1'b0;
    tick(2);
    // out-of-range channel
    do_reset();
    setup(0, 4, 2, 1'b0);
    for (int c = 0; c < N; c++) chk(2, c, 1'b0, 1, "bad_ch_pend");
    chk(3, 0, 1'b0, 2, "bad_ch_err_clear");
    cfg(3, 1, 1, 1'b1);
    tick();
    en = 3'b111;
    chk_str(0, 0, "10001", "bad_ch_ch0_pwm");
    chk_str(0, 1, "00000", "bad_ch_ch1_pwm");
    chk_str(1, 1, "11111", "bad_ch_ch1_wrap");
    tick(6);
    done = 1'b1;
    tick(3);
    $display("FAIL monitor_did_not_finish got=0 exp=1");
    $fatal(1);
  end
endmodule

// File: doc/pwm_bank.md
# pwm_bank

Multi-channel PWM generator for the sound path. It generalises the single-channel tone PWM to `CHANNELS` independent channels, each with its own period, compare and alignment mode. Each channel has a shadow register, so new settings take effect only at that channel's period boundary (glitch-free retune). It sits between the note/tone sequencer, which writes configuration, and the audio output pins.

## Interface

Parameters:
- `CHANNELS`, default 4: number of independent PWM channels (1..16).
- `WIDTH`, default 24: counter, period and compare width.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: synchronous, active-high reset.
- `en`, in, `CHANNELS`: per-channel run enable.
- `cfg_valid`, in, 1: config write request.
- `cfg_ready`, out, 1: config write accepted when `cfg_valid & cfg_ready`.
- `cfg_ch`, in, `CH_W = max(1, clog2(CHANNELS))`: target channel.
- `cfg_period`, in, `WIDTH`: new period `P`.
- `cfg_compare`, in, `WIDTH`: new compare `C`.
- `cfg_mode`, in, 1: 0 = edge-aligned, 1 = center-aligned.
- `cfg_err`, out, 1: one-cycle pulse when an accepted write has `cfg_ch >= CHANNELS`.
- `pend`, out, `CHANNELS`: shadow holds an unapplied write.
- `wrap`, out, `CHANNELS`: one-cycle pulse when the channel's counter returns to 0.
- `pwm`, out, `CHANNELS`: active-high PWM outputs.

## Operation

Per-channel state:
- Active registers: `ctr`, `dir` (up/down), `per_a`, `cmp_a`, `mode_a`.
- Shadow registers: `per_s`, `cmp_s`, `mode_s`.
- `pend` flag.

Reset (`rst`) values, all channels:
- `ctr = 0`, `dir = up`, all active and shadow registers = 0, `pend = 0`.
- `pwm = 0`, `wrap = 0`, `cfg_err = 0`, `cfg_ready = 0`.
- `rst` overrides every other input, including mid-period and mid-write.

Config writes:
- `cfg_ready` is 1 on every cycle not in reset.
- An accepted write stores P/C/mode into the target channel's shadow and sets its `pend`.
- A second write before the shadow is applied overwrites it (last write wins).
- An out-of-range `cfg_ch` changes no state and pulses `cfg_err` on the next cycle.

Load (shadow to active, clears `pend`):
- Occurs on a cycle where the next `ctr` value is 0 because of a wrap.
- Also occurs on any cycle the channel is disabled.
- If a write and a load hit the same channel in the same cycle, the load uses the previous shadow. The new write remains pending until the next boundary.

Counter step, on each cycle with `en[i] = 1`:
- Edge mode:
  - If `ctr >= per_a`: `ctr <= 0`, wrap.
  - Else: `ctr <= ctr + 1`.
  - Cycle length is P+1.
- Center mode, `dir = up`:
  - If `per_a == 0`: `ctr` stays 0, wrap every cycle.
  - Else if `ctr >= per_a`: `dir <= down`, `ctr <= ctr - 1`.
  - Else: `ctr <= ctr + 1`.
- Center mode, `dir = down`:
  - `ctr <= ctr - 1`.
  - When the new value is 0: `dir <= up`, wrap.
  - Cycle length is 2P for P ≥ 1.
- Output: `pwm <= (ctr_next < cmp_next)`, where `cmp_next` is `cmp_a` after any load in that cycle.
  - C = 0 gives constant 0.
  - C > P gives constant 1.
- Wrap pulse: `wrap <= 1` exactly on wrap cycles.
- Shrinking P below the current `ctr` is safe, because all up-count comparisons use `>=`.

Disabled channel (`en[i] = 0`):
- `ctr <= 0`, `dir <= up`, `pwm <= 0`, `wrap <= 0`.
- Any pending shadow loads immediately.
- After `en` rises, the first step starts from `ctr = 0`.

Channels are fully independent. No arithmetic overflows, since `ctr` never exceeds `per_a`.

## Timing

- All outputs are registered. `pwm`, `wrap` and `ctr` update on the same edge.
- Config write to `pend = 1`: 1 cycle.
- Write on a disabled channel: active registers updated 1 cycle after acceptance.
- Write on a running channel: takes effect at the first wrap strictly after the write cycle.
- `cfg_err`: 1 cycle after acceptance.
- `cfg_ready` rises on the first edge after `rst` deasserts.

## Structure

- Package `pwm_pkg` holds:
  - `pwm_mode_t` enum (`PWM_EDGE = 0`, `PWM_CENTER = 1`).
  - `dir_t` enum.
  - The `CH_W` width function.
- Sub-module `pwm_channel` holds one channel's active/shadow registers, counter and output.
- `pwm_bank` holds:
  - the write decode,
  - `cfg_err`,
  - a generate loop of `CHANNELS` instances.

## Test plan

1. **Edge mode, P=4, C=2, en=1:** `pwm` repeats 1,1,0,0,0 with period 5. `wrap` pulses every 5 cycles, coincident with `ctr = 0`.
2. **Boundary compares, P=4:** C=0 gives `pwm` constant 0. C=6 gives `pwm` constant 1. P=0, C=1 gives constant 1 with `wrap` high every cycle.
3. **Center mode, P=3, C=2:** `ctr` sequence is 0,1,2,3,2,1. `pwm` is 1,1,0,0,0,1 with period 6, and `wrap` pulses once per 6 cycles.
4. **Shadow update:**
   - Channel 1 runs P=4, C=2. Mid-period, write P=9, C=5 to channel 1.
   - `pend[1] = 1` and the old waveform continues until the wrap.
   - Then a period of 10 with high time 5, and `pend[1]` clears.
   - Channel 0 is unaffected.
   - Also write twice before the wrap: only the second write is applied.
5. **Same-cycle write and load:** a write to channel 0 on its wrap cycle is applied one full period later.
6. **Disable, reset and bad address:**
   - `en` low mid-period: `pwm = 0`, `ctr = 0` next cycle, and any pending write loads.
   - `rst` mid-period: all outputs return to reset values.
   - Write with `cfg_ch = CHANNELS`: `cfg_err` pulses and no channel changes.
